// File: rtl/boss_ctrl_pkg.sv
// Shared types and constants for the boss encounter controller.
// BOSS_CTRL_LFSR_EN enables random re-patrol; its seed and taps live here.
package boss_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPAWN   = 3'd1,
    S_HOLD    = 3'd2,
    S_PATROL  = 3'd3,
    S_FLYDOWN = 3'd4,
    S_RISE    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [8:0] HOLD_BASE    = 9'd120;
  localparam logic [8:0] PATROL_BASE  = 9'd240;
  localparam logic [8:0] FLY_TIMEOUT  = 9'd120;
  localparam logic [8:0] RISE_TIMEOUT = 9'd300;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // medium wins over hard; 3/4 is built as 1/2 + 1/4
  function automatic logic [8:0] dur(
    input logic [8:0] base,
    input logic       hard,
    input logic       med
  );
    if (med)
      dur = (base >> 1) + (base >> 2);
    else if (hard)
      dur = base >> 1;
    else
      dur = base;
  endfunction

endpackage

// File: rtl/boss_ctrl_timer.sv
// Shared 9-bit frame down-counter for the boss controller.
// Loads a value, counts to 0 and saturates there.
module boss_ctrl_timer (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       i_load,
  input  logic [8:0] i_val,
  output logic       o_expired
);

  logic [8:0] r_cnt;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      r_cnt <= 9'd0;
    else if (i_load)
      r_cnt <= i_val;
    else if (r_cnt != 9'd0)
      r_cnt <= r_cnt - 9'd1;
  end

  assign o_expired = (r_cnt == 9'd0);

endmodule

// File: rtl/boss_controller.sv
// Boss encounter sequencer, Moore FSM clocked once per frame.
// Optional BOSS_CTRL_LFSR_EN adds up to two random PATROL repeats.
module boss_controller
  import boss_ctrl_pkg::*;
(
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [2:0] difficulty,
  input  logic       hit_top,
  input  logic       hit_bottom,
  input  logic       beat_Boss,
  output logic       spawn,
  output logic       hold,
  output logic       back_and_forth,
  output logic       flydown,
  output logic       rise,
  output logic       Boss_exists,
  output logic       boss_done,
  output logic [2:0] state_code
);

  state_t     r_state;
  state_t     w_nxt;
  logic       r_first;
  logic       w_load;
  logic [8:0] w_ld_val;
  logic       w_exp;
  logic [8:0] w_hold_n;
  logic [8:0] w_pat_n;
  logic       w_active;
  logic       w_unused;

  assign w_unused = difficulty[0];
  assign w_hold_n = dur(HOLD_BASE, difficulty[2], difficulty[1]) - 9'd1;
  assign w_pat_n  = dur(PATROL_BASE, difficulty[2], difficulty[1]) - 9'd1;
  assign w_active = (r_state == S_HOLD) || (r_state == S_PATROL) ||
                    (r_state == S_FLYDOWN) || (r_state == S_RISE);

  boss_ctrl_timer u_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .i_load    (w_load),
    .i_val     (w_ld_val),
    .o_expired (w_exp)
  );

`ifdef BOSS_CTRL_LFSR_EN
  logic [7:0] r_lfsr;
  logic [1:0] r_repat;
  logic       w_repat;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_lfsr  <= LFSR_SEED;
      r_repat <= 2'd0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
      if (r_state == S_HOLD)
        r_repat <= 2'd0;
      else if (w_repat)
        r_repat <= r_repat + 2'd1;
    end
  end
`endif

  always_comb begin
    w_nxt    = r_state;
    w_load   = 1'b0;
    w_ld_val = 9'd0;
`ifdef BOSS_CTRL_LFSR_EN
    w_repat  = 1'b0;
`endif
    if (w_active && beat_Boss) begin
      w_nxt = S_DONE;
    end else if (w_active && !start) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:
          if (start && !beat_Boss)
            w_nxt = S_SPAWN;
        S_SPAWN: begin
          w_nxt    = S_HOLD;
          w_load   = 1'b1;
          w_ld_val = w_hold_n;
        end
        S_HOLD:
          if (w_exp) begin
            w_nxt    = S_PATROL;
            w_load   = 1'b1;
            w_ld_val = w_pat_n;
          end
        S_PATROL:
          if (w_exp) begin
`ifdef BOSS_CTRL_LFSR_EN
            if (!r_lfsr[0] && r_repat != 2'd2) begin
              w_repat  = 1'b1;
              w_load   = 1'b1;
              w_ld_val = w_pat_n;
            end else begin
              w_nxt    = S_FLYDOWN;
              w_load   = 1'b1;
              w_ld_val = FLY_TIMEOUT - 9'd1;
            end
`else
            w_nxt    = S_FLYDOWN;
            w_load   = 1'b1;
            w_ld_val = FLY_TIMEOUT - 9'd1;
`endif
          end
        // boss flags lag a frame, so the first frame's value is stale
        S_FLYDOWN:
          if (w_exp || (hit_bottom && !r_first)) begin
            w_nxt    = S_RISE;
            w_load   = 1'b1;
            w_ld_val = RISE_TIMEOUT - 9'd1;
          end
        S_RISE:
          if (w_exp || (hit_top && !r_first)) begin
            w_nxt    = S_HOLD;
            w_load   = 1'b1;
            w_ld_val = w_hold_n;
          end
        S_DONE:
          if (!start)
            w_nxt = S_IDLE;
        default:
          w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_first        <= 1'b0;
      spawn          <= 1'b0;
      hold           <= 1'b0;
      back_and_forth <= 1'b0;
      flydown        <= 1'b0;
      rise           <= 1'b0;
      Boss_exists    <= 1'b0;
      boss_done      <= 1'b0;
      state_code     <= 3'd0;
    end else begin
      r_state        <= w_nxt;
      r_first        <= (w_nxt != r_state);
      spawn          <= (w_nxt == S_SPAWN);
      hold           <= (w_nxt == S_HOLD);
      back_and_forth <= (w_nxt == S_PATROL);
      flydown        <= (w_nxt == S_FLYDOWN);
      rise           <= (w_nxt == S_RISE);
      Boss_exists    <= (w_nxt == S_HOLD) || (w_nxt == S_PATROL) ||
                        (w_nxt == S_FLYDOWN) || (w_nxt == S_RISE);
      boss_done      <= (w_nxt == S_DONE);
      state_code     <= w_nxt;
    end
  end

endmodule

// File: tb/tb_boss_controller.sv
// Directed self-checking bench for boss_controller.
// Default build checks exact durations; BOSS_CTRL_LFSR_EN checks re-patrol limit.
module tb_boss_controller;

  logic       Reset;
  logic       frame_clk;
  logic       start;
  logic [2:0] difficulty;
  logic       hit_top;
  logic       hit_bottom;
  logic       beat_Boss;
  logic       spawn;
  logic       hold;
  logic       back_and_forth;
  logic       flydown;
  logic       rise;
  logic       Boss_exists;
  logic       boss_done;
  logic [2:0] state_code;
  logic [9:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  boss_controller dut (
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .start          (start),
    .difficulty     (difficulty),
    .hit_top        (hit_top),
    .hit_bottom     (hit_bottom),
    .beat_Boss      (beat_Boss),
    .spawn          (spawn),
    .hold           (hold),
    .back_and_forth (back_and_forth),
    .flydown        (flydown),
    .rise           (rise),
    .Boss_exists    (Boss_exists),
    .boss_done      (boss_done),
    .state_code     (state_code)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  assign obs = {spawn, hold, back_and_forth, flydown, rise,
                Boss_exists, boss_done, state_code};

  // {spawn,hold,baf,fly,rise,exists,done,code}
  function automatic logic [9:0] eo(input int s);
    case (s)
      1:       eo = 10'b1000000_001;
      2:       eo = 10'b0100010_010;
      3:       eo = 10'b0010010_011;
      4:       eo = 10'b0001010_100;
      5:       eo = 10'b0000110_101;
      6:       eo = 10'b0000001_110;
      default: eo = 10'b0000000_000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  // check state s on each of n frames, ending just after the n-th edge
  task automatic stay(input string tag, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {22'd0, obs}, {22'd0, eo(s)});
      step(1);
    end
  endtask

  initial begin
    Reset      = 1'b1;
    start      = 1'b0;
    difficulty = 3'b000;
    hit_top    = 1'b0;
    hit_bottom = 1'b0;
    beat_Boss  = 1'b0;
    #12;
    chk("reset", {22'd0, obs}, 32'd0);
    Reset = 1'b0;
    step(1);
    chk("idle", {22'd0, obs}, {22'd0, eo(0)});
    start = 1'b1;
    step(1);
    chk("spawn", {22'd0, obs}, {22'd0, eo(1)});
    step(1);

`ifndef BOSS_CTRL_LFSR_EN
    stay("hold_easy", 2, 120);
    stay("patrol_easy", 3, 240);
    stay("fly_timeout", 4, 120);
    hit_top = 1'b1;
    chk("rise_first", {22'd0, obs}, {22'd0, eo(5)});
    step(1);
    hit_top = 1'b0;
    stay("rise_mask", 5, 8);
    hit_top = 1'b1;
    chk("rise_f10", {22'd0, obs}, {22'd0, eo(5)});
    step(1);
    hit_top = 1'b0;
    difficulty = 3'b100;
    stay("hold_sampled", 2, 120);
    stay("patrol_hard", 3, 120);
    hit_bottom = 1'b1;
    chk("fly_first", {22'd0, obs}, {22'd0, eo(4)});
    step(1);
    hit_bottom = 1'b0;
    stay("fly_mask", 4, 3);
    hit_bottom = 1'b1;
    chk("fly_f5", {22'd0, obs}, {22'd0, eo(4)});
    step(1);
    hit_bottom = 1'b0;
    stay("rise_timeout", 5, 300);
    difficulty = 3'b110;
    stay("hold_hard", 2, 60);
    stay("patrol_med", 3, 180);
    stay("fly_short", 4, 1);
    hit_bottom = 1'b1;
    step(1);
    hit_bottom = 1'b0;
    stay("rise_short", 5, 1);
    hit_top = 1'b1;
    step(1);
    hit_top = 1'b0;
    stay("hold_med", 2, 90);
    stay("patrol_pre", 3, 5);
    beat_Boss = 1'b1;
    start     = 1'b0;
    step(1);
    chk("done", {22'd0, obs}, {22'd0, eo(6)});
    step(1);
    chk("done_idle", {22'd0, obs}, {22'd0, eo(0)});
    start = 1'b1;
    step(1);
    stay("beat_ignore", 0, 3);

    Reset = 1'b1;
    beat_Boss = 1'b0;
    difficulty = 3'b100;
    step(1);
    Reset = 1'b0;
    step(1);
    chk("restart_spawn", {22'd0, obs}, {22'd0, eo(1)});
    step(1);
    stay("abort_hold", 2, 4);
    start = 1'b0;
    step(1);
    chk("abort_idle", {22'd0, obs}, {22'd0, eo(0)});
    start = 1'b1;
    step(2);
    stay("hold_hard2", 2, 60);
    stay("patrol_hard2", 3, 120);
    stay("fly_pre_rst", 4, 3);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_reset", {22'd0, obs}, 32'd0);
    #3;
    Reset = 1'b0;
    step(1);
    chk("post_reset", {22'd0, obs}, {22'd0, eo(1)});
`else
    begin
      int run;
      int runs;
      difficulty = 3'b100;
      hit_top    = 1'b1;
      hit_bottom = 1'b1;
      run  = 0;
      runs = 0;
      for (int f = 0; f < 1000; f++) begin
        if (back_and_forth) begin
          run++;
        end else if (run != 0) begin
          runs++;
          chk("patrol_max", run <= 360, 32'd1);
          chk("patrol_mult", run % 120, 32'd0);
          run = 0;
        end
        step(1);
      end
      chk("patrol_seen", runs > 0, 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/boss_controller.md
# boss_controller

Frame-rate Moore FSM that sequences the boss encounter. It sits directly upstream of the boss movement/collision block. It drives that block's spawn, Boss_exists, hold, back_and_forth, flydown and rise controls, and consumes the hit_top, hit_bottom and beat_Boss flags it returns. It also reports encounter completion to the game-level FSM.

## Interface
- HOLD_BASE, 120: HOLD duration in frames, easy difficulty.
- PATROL_BASE, 240: BACK_AND_FORTH duration in frames, easy difficulty.
- FLY_TIMEOUT, 120: maximum FLYDOWN frames without hit_bottom.
- RISE_TIMEOUT, 300: maximum RISE frames without hit_top.
- Reset  in  1  reset Reset, asynchronous, active-high
- frame_clk  in  1  clock frame_clk (one edge per video frame)
- start  in  1  level; game FSM requests the boss encounter
- difficulty  in  3  same encoding as boss block; [1] medium, [2] hard, [1] has priority, else easy
- hit_top, hit_bottom, beat_Boss  in  1 each  status flags from boss block
- spawn, hold, back_and_forth, flydown, rise  out  1 each  mutually exclusive boss commands
- Boss_exists  out  1  boss alive and active
- boss_done  out  1  encounter won
- state_code  out  3  current state, for debug/HUD

## Operation
- States and encodings:
  - IDLE=0, SPAWN=1, HOLD=2, PATROL=3, FLYDOWN=4, RISE=5, DONE=6.
- Transitions:
  - IDLE→SPAWN: start=1 and beat_Boss=0. While beat_Boss=1, start is ignored, because the boss block clears it only on Reset.
  - SPAWN→HOLD: unconditionally after 1 frame.
  - HOLD→PATROL: hold timer expires.
  - PATROL→FLYDOWN: patrol timer expires.
  - FLYDOWN→RISE: hit_bottom=1 or FLY_TIMEOUT expires.
  - RISE→HOLD: hit_top=1 or RISE_TIMEOUT expires.
  - HOLD/PATROL/FLYDOWN/RISE→DONE: beat_Boss=1. This has priority over every other transition in the same frame.
  - HOLD/PATROL/FLYDOWN/RISE→IDLE: start=0 (encounter aborted). beat_Boss takes priority over this.
  - DONE→IDLE: start=0.
- Outputs, decoded from state only:
  - spawn=1 in SPAWN only.
  - hold, back_and_forth, flydown and rise are each 1 in their own state only.
  - Boss_exists=1 in HOLD, PATROL, FLYDOWN and RISE.
  - boss_done=1 in DONE.
  - SPAWN holds Boss_exists=0, so the boss block loads its start position and health.
- Durations:
  - HOLD is HOLD_BASE, ×3/4 for medium (90), ×1/2 for hard (60).
  - PATROL is PATROL_BASE, ×3/4 for medium (180), ×1/2 for hard (120).
  - Computed with shifts and adds, 9-bit unsigned.
  - difficulty is sampled when the timer loads.
- Stale flag masking:
  - The boss block's hit_top and hit_bottom are registered and lag one frame.
  - The FSM ignores hit_bottom on the first FLYDOWN frame and hit_top on the first RISE frame.

## Timing
- All outputs are registered and change on the frame_clk edge that enters the new state.
- Reset values:
  - state IDLE.
  - spawn, hold, back_and_forth, flydown, rise, Boss_exists and boss_done all 0.
  - state_code 0.
  - Timer 0.
- A state with duration N asserts its command for exactly N frames.
- The timer loads N-1 on entry and transitions on the edge after the count reaches 0.
- start→spawn latency is 1 frame; spawn→hold is 1 frame.
- Timeout counters do not wrap. Expiry forces the transition even if the boss flag never arrives.
- Reset mid-encounter returns to IDLE immediately, with all outputs 0.

## Configuration
- BOSS_CTRL_LFSR_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on Reset) advances every frame.
  - At PATROL expiry, if LFSR[0]=0, the FSM re-enters PATROL with a reloaded timer instead of FLYDOWN.
  - At most 2 consecutive re-patrols; the third expiry forces FLYDOWN.
- Not defined: PATROL always proceeds to FLYDOWN, and no LFSR logic is synthesized.

## Structure
- Package boss_ctrl_pkg holds:
  - the state enum (3-bit, encodings above);
  - the HOLD/PATROL/timeout default constants;
  - the LFSR seed and taps.
- Sub-module boss_ctrl_timer: 9-bit down-counter with load, load value, expired flag and saturation at 0. One instance is shared by all timed states.

## Test plan
- Reset, then start=1, easy: spawn high for exactly 1 frame, then hold=1 and Boss_exists=1 for exactly 120 frames, then back_and_forth for 240 frames.
- Hard difficulty: HOLD lasts 60 frames and PATROL 120. Medium (difficulty=3'b010): 90 and 180.
- In FLYDOWN, assert hit_bottom at frame 5 → rise on the next edge. Hold hit_top high on the first RISE frame → ignored. Assert it at frame 10 → HOLD.
- Never assert hit_bottom → RISE entered after exactly 120 FLYDOWN frames.
- Assert beat_Boss and start=0 in the same PATROL frame → DONE with boss_done=1 and Boss_exists=0. Then IDLE next frame, and a new start is ignored while beat_Boss=1.
- Reset asserted mid-FLYDOWN → all outputs 0 asynchronously and state_code=0. With BOSS_CTRL_LFSR_EN defined, no more than 2 consecutive PATROL re-entries over 1000 frames.
